step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the step-count request.
REQ-002 SHALL have parameter POS_W, default 32: width of the signed absolute position.
REQ-003 SHALL have port clk_in, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port step_clk, input, 1, the divided step clock from frq_divider, synchronous to clk_in; each rising edge is one step request.
REQ-006 SHALL have port start, input, 1, a one-cycle move request.
REQ-007 SHALL have port steps_to_move, input, CNT_W, the number of steps to take, sampled on an accepted start.
REQ-008 SHALL have port dir, input, 1, direction (1 = forward, 0 = reverse), sampled on an accepted start.
REQ-009 SHALL have port half_step, input, 1, the mode select (1 = half-step, 0 = full-step), sampled on an accepted start.
REQ-010 SHALL have port enable, input, 1, the driver enable; when low, coils are de-energised.
REQ-011 SHALL have port abort, input, 1, which terminates the current move.
REQ-012 SHALL have port coils, output, 4, coil drive in order {A, B, A_n, B_n}.
REQ-013 SHALL have port busy, output, 1, high while a move is in progress.
REQ-014 SHALL have port done, output, 1, a one-cycle pulse when a move completes normally.
REQ-015 SHALL have port aborted, output, 1, a one-cycle pulse when a move is terminated by abort.
REQ-016 SHALL have port position, output, POS_W, the signed step position.

Function
REQ-017 SHALL detect step edges as step_clk & ~step_clk_d, where step_clk_d is step_clk registered once.
REQ-018 SHALL implement FSM states IDLE, RUN and FIN.
REQ-019 SHALL, in IDLE, accept start when abort is low: latch steps_to_move, dir and half_step.
- steps_to_move ≠ 0 → RUN.
- steps_to_move = 0 → FIN.
REQ-020 SHALL ignore start in RUN and FIN.
REQ-021 SHALL give abort priority over start in the same cycle.
REQ-022 SHALL, in RUN, on a step edge with enable high:
- advance phase_idx (3-bit, mod 8) by +1 (half-step) or +2 (full-step), negated when dir = 0;
- decrement remaining;
- update position ±1 (two's-complement wrap).
REQ-023 SHALL, in full-step mode with phase_idx even, advance by ±1 on the first step so phase_idx becomes odd; that step counts as one step.
REQ-024 SHALL ignore step edges in RUN while enable is low; FSM stays in RUN and remaining is unchanged.
REQ-025 SHALL ignore a step edge coinciding with the start-acceptance cycle; counting begins the cycle after entry to RUN.
REQ-026 SHALL go RUN → FIN on the step that makes remaining = 0.
REQ-027 SHALL go FIN → IDLE after one cycle, with done = 1 for exactly that cycle.
REQ-028 SHALL, on abort in RUN, go to IDLE next cycle, pulse aborted for one cycle, and assert no done.
REQ-029 SHALL ignore abort in FIN.
REQ-030 SHALL drive busy = 1 in RUN and FIN.
REQ-031 SHALL drive coils = TABLE[phase_idx] when enable = 1, else 4'b0000; coils is combinational from registered state.
REQ-032 SHALL use TABLE[0..7] = 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.

Reset
REQ-033 SHALL, on rst, set state IDLE, phase_idx 1, remaining 0, position 0, step_clk_d 0, and busy, done and aborted 0.
REQ-034 SHALL let rst mid-move override everything: no done or aborted pulse, and position is cleared.

Configuration
REQ-035 SHALL compile half-step support only when macro STEP_SEQ_HALF_STEP_EN is defined.
REQ-036 SHALL, without STEP_SEQ_HALF_STEP_EN, ignore half_step, always use full-step, and never leave phase_idx even after the first step.

Structure
REQ-037 SHALL place the FSM state enum, TABLE constant and coil-width constant in shared package step_pkg.
REQ-038 SHALL implement edge detection in sub-module step_edge_det (ports clk_in, rst, in, rise).

Verification
REQ-039 SHALL cover a full-step forward move: start, steps_to_move = 4, dir = 1, enable = 1, 4 step edges → coils 0110, 0011, 1001, 1100; position = 4; done one cycle after the 4th edge; busy falls the following cycle.
REQ-040 SHALL cover a half-step reverse move (macro defined): start, steps_to_move = 3, dir = 0 → phase_idx 0, 7, 6; coils 1000, 1001, 0001; position = -3.
REQ-041 SHALL cover a zero-length move: start with steps_to_move = 0 → busy for 1 cycle, done pulse, position and coils unchanged.
REQ-042 SHALL cover abort: steps_to_move = 10, abort after 3 edges → aborted pulse, no done, position = 3, busy = 0 next cycle; a start concurrent with abort is not accepted.
REQ-043 SHALL cover enable dropped mid-move for 5 step edges → coils 0000, remaining and position frozen; the move resumes after enable returns and completes with the correct count.
REQ-044 SHALL cover position wrap: POS_W = 4, position at 7, one forward step → position = -8.

Source files
------------

// File: rtl/step_pkg.sv
// Shared definitions for the stepper-motor sequencer: FSM states, coil width
// and the eight-entry phase-to-coil table. Half-step support is compiled in
// only when STEP_SEQ_HALF_STEP_EN is defined.
package step_pkg;

  localparam int COIL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Coil patterns {A, B, A_n, B_n}, indexed by phase; entry 0 is rightmost.
  // Odd phases energise two coils (full-step), even phases energise one.
  localparam logic [7:0][COIL_W-1:0] STEP_TABLE = {
    4'b1001,  // 7
    4'b0001,  // 6
    4'b0011,  // 5
    4'b0010,  // 4
    4'b0110,  // 3
    4'b0100,  // 2
    4'b1100,  // 1
    4'b1000   // 0
  };

endpackage

// File: rtl/step_edge_det.sv
// Rising-edge detector for the divided step clock. The input is already
// synchronous to clk_in, so a single delay register is enough.
module step_edge_det (
  input  logic clk_in,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic in_q;

  // Remember the previous sample of the input.
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    if (rst) in_q <= 1'b0;
    else     in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/step_sequencer.sv
// Stepper-motor move sequencer: accepts a move request, advances the coil
// phase on each step-clock edge, tracks the signed absolute position and
// reports completion or abort. Define STEP_SEQ_HALF_STEP_EN to enable the
// half-step mode; without it half_step is ignored and moves are full-step.
module step_sequencer
  import step_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int POS_W = 32
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              step_clk,
  input  logic              start,
  input  logic [CNT_W-1:0]  steps_to_move,
  input  logic              dir,
  input  logic              half_step,
  input  logic              enable,
  input  logic              abort,
  output logic [COIL_W-1:0] coils,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [POS_W-1:0]  position
);

  state_e           state_q;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [POS_W-1:0] position_q, position_d;
  logic [2:0]       phase_q, phase_d;
  logic [2:0]       delta;
  logic             dir_q;
  logic             busy_q, done_q, aborted_q;
  logic             step_rise;
  logic             mode_half;

  step_edge_det u_edge_det (
    .clk_in (clk_in),
    .rst    (rst),
    .in     (step_clk),
    .rise   (step_rise)
  );

`ifdef STEP_SEQ_HALF_STEP_EN
  logic half_q;
  assign mode_half = half_q;
`else
  logic unused_half_step;
  assign unused_half_step = half_step;
  assign mode_half        = 1'b0;
`endif

  // Values the counters take if the current cycle carries an accepted step.
  always_comb begin
    // NOTE: every output of this block is assigned on every path, so no latch.
    delta       = (mode_half || !phase_q[0]) ? 3'd1 : 3'd2;
    phase_d     = dir_q ? (phase_q + delta) : (phase_q - delta);
    position_d  = dir_q ? (position_q + POS_W'(1)) : (position_q - POS_W'(1));
    remaining_d = remaining_q - CNT_W'(1);
  end

  // Move-control FSM with registered status outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= 3'd1;
      remaining_q <= '0;
      position_q  <= '0;
      dir_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
`ifdef STEP_SEQ_HALF_STEP_EN
      half_q      <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Abort in the same cycle blocks acceptance.
          if (start && !abort) begin
            remaining_q <= steps_to_move;
            dir_q       <= dir;
`ifdef STEP_SEQ_HALF_STEP_EN
            half_q      <= half_step;
`endif
            busy_q      <= 1'b1;
            if (steps_to_move != '0) begin
              state_q <= RUN;
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else if (step_rise && enable) begin
            phase_q     <= phase_d;
            position_q  <= position_d;
            remaining_q <= remaining_d;
            if (remaining_q == CNT_W'(1)) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign coils    = enable ? STEP_TABLE[phase_q] : '0;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign position = position_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed testbench for step_sequencer. A second instance with POS_W = 4
// shares all inputs and is used for the position-wrap scenario.
module tb_step_sequencer;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        step_clk = 1'b0;
  logic        start = 1'b0;
  logic [15:0] steps_to_move = '0;
  logic        dir = 1'b1;
  logic        half_step = 1'b0;
  logic        enable = 1'b1;
  logic        abort = 1'b0;
  logic [3:0]  coils, coils_w;
  logic        busy, done, aborted;
  logic        busy_w, done_w, aborted_w;
  logic [31:0] position;
  logic [3:0]  position_w;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  step_sequencer #(.CNT_W(16), .POS_W(32)) dut (
    .clk_in(clk_in), .rst(rst), .step_clk(step_clk), .start(start),
    .steps_to_move(steps_to_move), .dir(dir), .half_step(half_step),
    .enable(enable), .abort(abort), .coils(coils), .busy(busy),
    .done(done), .aborted(aborted), .position(position)
  );

  step_sequencer #(.CNT_W(16), .POS_W(4)) dut_w (
    .clk_in(clk_in), .rst(rst), .step_clk(step_clk), .start(start),
    .steps_to_move(steps_to_move), .dir(dir), .half_step(half_step),
    .enable(enable), .abort(abort), .coils(coils_w), .busy(busy_w),
    .done(done_w), .aborted(aborted_w), .position(position_w)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; step_clk = 1'b0; enable = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic start_move(input logic [15:0] n, input logic d, input logic h);
    start = 1'b1; steps_to_move = n; dir = d; half_step = h;
    tick();
    start = 1'b0;
  endtask

  // One step-clock period: high for one cycle, then low for one cycle.
  task automatic step_pulse(output logic done_seen);
    step_clk = 1'b1; tick(); done_seen = done;
    step_clk = 1'b0; tick();
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0 || aborted !== 1'b0) begin bad++; $display("FAIL reset_pulses: got done=%b aborted=%b want 0 0", done, aborted); end
    total++; if (position !== 32'd0) begin bad++; $display("FAIL reset_pos: got %0d want 0", position); end
    total++; if (coils !== 4'b1100) begin bad++; $display("FAIL reset_coils: got %b want 1100", coils); end
  endtask

  task automatic test_full_forward();
    logic [3:0] exp_c [4] = '{4'b0110, 4'b0011, 4'b1001, 4'b1100};
    logic ds;
    apply_reset();
    start_move(16'd4, 1'b1, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fwd_busy: got %b want 1", busy); end
    for (int i = 0; i < 4; i++) begin
      step_pulse(ds);
      total++; if (coils !== exp_c[i]) begin bad++; $display("FAIL fwd_coils%0d: got %b want %b", i, coils, exp_c[i]); end
      total++; if (ds !== (i == 3)) begin bad++; $display("FAIL fwd_done%0d: got %b want %b", i, ds, (i == 3)); end
    end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL fwd_end: got busy=%b done=%b want 0 0", busy, done); end
    total++; if (position !== 32'd4) begin bad++; $display("FAIL fwd_pos: got %0d want 4", position); end
  endtask

  task automatic test_reverse_mode();
`ifdef STEP_SEQ_HALF_STEP_EN
    logic [3:0] exp_r [3] = '{4'b1000, 4'b1001, 4'b0001};
    logic [3:0] exp_f [2] = '{4'b1001, 4'b1100};
`else
    logic [3:0] exp_r [3] = '{4'b1001, 4'b0011, 4'b0110};
    logic [3:0] exp_f [2] = '{4'b0011, 4'b1001};
`endif
    logic ds;
    apply_reset();
    start_move(16'd3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step_pulse(ds);
      total++; if (coils !== exp_r[i]) begin bad++; $display("FAIL rev_coils%0d: got %b want %b", i, coils, exp_r[i]); end
    end
    total++; if (ds !== 1'b1) begin bad++; $display("FAIL rev_done: got %b want 1", ds); end
    total++; if (position !== 32'hFFFF_FFFD) begin bad++; $display("FAIL rev_pos: got %h want fffffffd", position); end
    // Full-step forward from wherever the reverse move left the phase.
    start_move(16'd2, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step_pulse(ds);
      total++; if (coils !== exp_f[i]) begin bad++; $display("FAIL refwd_coils%0d: got %b want %b", i, coils, exp_f[i]); end
    end
    total++; if (position !== 32'hFFFF_FFFF) begin bad++; $display("FAIL refwd_pos: got %h want ffffffff", position); end
  endtask

  task automatic test_zero_length();
    apply_reset();
    start_move(16'd0, 1'b1, 1'b0);
    total++; if (busy !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL zero_fin: got busy=%b done=%b want 1 1", busy, done); end
    abort = 1'b1;  // abort while finishing is ignored
    tick();
    abort = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin bad++; $display("FAIL zero_end: got busy=%b done=%b aborted=%b want 0 0 0", busy, done, aborted); end
    total++; if (position !== 32'd0 || coils !== 4'b1100) begin bad++; $display("FAIL zero_state: got pos=%0d coils=%b want 0 1100", position, coils); end
  endtask

  task automatic test_start_edge();
    apply_reset();
    step_clk = 1'b1;  // edge in the acceptance cycle must be ignored
    start_move(16'd1, 1'b1, 1'b0);
    tick();
    total++; if (position !== 32'd0 || busy !== 1'b1) begin bad++; $display("FAIL sedge_ignored: got pos=%0d busy=%b want 0 1", position, busy); end
    step_clk = 1'b0; tick();
    step_clk = 1'b1; tick();
    total++; if (position !== 32'd1 || done !== 1'b1 || coils !== 4'b0110) begin bad++; $display("FAIL sedge_step: got pos=%0d done=%b coils=%b want 1 1 0110", position, done, coils); end
    step_clk = 1'b0; tick();
  endtask

  task automatic test_abort();
    logic ds;
    apply_reset();
    start_move(16'd10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step_pulse(ds);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    total++; if (aborted !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_pulse: got aborted=%b done=%b busy=%b want 1 0 0", aborted, done, busy); end
    total++; if (position !== 32'd3 || coils !== 4'b1001) begin bad++; $display("FAIL abort_state: got pos=%0d coils=%b want 3 1001", position, coils); end
    tick();
    total++; if (aborted !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_after: got aborted=%b busy=%b want 0 0", aborted, busy); end
    // In IDLE, abort wins over a concurrent start.
    abort = 1'b1; start = 1'b1; steps_to_move = 16'd5;
    tick();
    abort = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0 || aborted !== 1'b0) begin bad++; $display("FAIL abort_idle_start: got busy=%b aborted=%b want 0 0", busy, aborted); end
  endtask

  task automatic test_enable_drop();
    logic ds;
    apply_reset();
    start_move(16'd4, 1'b1, 1'b0);
    step_pulse(ds);
    enable = 1'b0;
    tick();
    total++; if (coils !== 4'b0000) begin bad++; $display("FAIL en_coils_off: got %b want 0000", coils); end
    for (int i = 0; i < 5; i++) step_pulse(ds);
    total++; if (position !== 32'd1 || busy !== 1'b1) begin bad++; $display("FAIL en_frozen: got pos=%0d busy=%b want 1 1", position, busy); end
    enable = 1'b1;
    tick();
    total++; if (coils !== 4'b0110) begin bad++; $display("FAIL en_coils_on: got %b want 0110", coils); end
    for (int i = 0; i < 3; i++) begin
      step_pulse(ds);
      total++; if (ds !== (i == 2)) begin bad++; $display("FAIL en_done%0d: got %b want %b", i, ds, (i == 2)); end
    end
    total++; if (position !== 32'd4 || coils !== 4'b1100) begin bad++; $display("FAIL en_end: got pos=%0d coils=%b want 4 1100", position, coils); end
  endtask

  task automatic test_rst_mid_move();
    logic ds;
    apply_reset();
    start_move(16'd10, 1'b1, 1'b0);
    step_pulse(ds); step_pulse(ds);
    rst = 1'b1;
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin bad++; $display("FAIL rstmid_flags: got busy=%b done=%b aborted=%b want 0 0 0", busy, done, aborted); end
    total++; if (position !== 32'd0 || coils !== 4'b1100) begin bad++; $display("FAIL rstmid_state: got pos=%0d coils=%b want 0 1100", position, coils); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic ds;
    apply_reset();
    start_move(16'd7, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step_pulse(ds);
    total++; if (position_w !== 4'd7 || position !== 32'd7) begin bad++; $display("FAIL wrap_pre: got narrow=%h wide=%0d want 7 7", position_w, position); end
    start_move(16'd1, 1'b1, 1'b0);
    step_pulse(ds);
    total++; if (position_w !== 4'h8) begin bad++; $display("FAIL wrap_pos: got %h want 8", position_w); end
    total++; if (position !== 32'd8) begin bad++; $display("FAIL wrap_wide: got %0d want 8", position); end
  endtask

  initial begin
    test_reset();
    test_full_forward();
    test_reverse_mode();
    test_zero_length();
    test_start_edge();
    test_abort();
    test_enable_drop();
    test_rst_mid_move();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
